// File: rtl/bram_to_axi_read_pkg.sv
// Shared types and encodings for the BRAM-to-AXI read bridge.
package bram_to_axi_read_pkg;

   localparam int unsigned LEN_W   = 8;
   localparam int unsigned BURST_W = 2;
   localparam int unsigned RESP_W  = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
   localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
   localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;

   localparam logic [RESP_W-1:0] RESP_OKAY = 2'b00;

   // WRAP and the reserved encoding both walk forward like INCR; only FIXED holds.
   function automatic logic burst_advances(input logic [BURST_W-1:0] burst);
      case (burst)
         BURST_FIXED:            return 1'b0;
         BURST_INCR, BURST_WRAP: return 1'b1;
         default:                return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/bram_to_axi_read_if.sv
// AXI read-address and read-data channels of the bridge.
interface bram_to_axi_read_if #(
   parameter int unsigned ID_WIDTH   = 16,
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned ADDR_WIDTH = 14
);
   logic [ID_WIDTH-1:0]   S_AXI_ARID;
   logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
   logic [7:0]            S_AXI_ARLEN;
   logic [1:0]            S_AXI_ARBURST;
   logic                  S_AXI_ARVALID;
   logic                  S_AXI_ARREADY;

   logic [ID_WIDTH-1:0]   S_AXI_RID;
   logic [DATA_WIDTH-1:0] S_AXI_RDATA;
   logic [1:0]            S_AXI_RRESP;
   logic                  S_AXI_RLAST;
   logic                  S_AXI_RVALID;
   logic                  S_AXI_RREADY;

   modport master (
      output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
      output S_AXI_RREADY,
      input  S_AXI_ARREADY,
      input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID
   );

   modport slave (
      input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
      input  S_AXI_RREADY,
      output S_AXI_ARREADY,
      output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID
   );
endinterface

// File: rtl/bram_to_axi_read_rd_skid_fifo.sv
// Two-entry FIFO absorbing BRAM read data while the R channel is stalled.
module rd_skid_fifo #(
   parameter int unsigned WIDTH = 129
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;

   assign head_data = mem[rd_ptr];

   // Storage, pointers and occupancy; the caller never pushes into a full FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + 2'(push) - 2'(pop);
      end
   end

endmodule

// File: rtl/bram_to_axi_read.sv
// Serves AXI read bursts from a single-cycle-latency BRAM port.
module bram_to_axi_read
   import bram_to_axi_read_pkg::*;
#(
   parameter int unsigned C_S_AXI_ID_WIDTH   = 16,
   parameter int unsigned C_S_AXI_DATA_WIDTH = 128,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 14
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESET,
   bram_to_axi_read_if.slave             s_axi,
   output logic                          bram_clk,
   output logic                          bram_rst,
   output logic                          bram_en,
   output logic [C_S_AXI_ADDR_WIDTH-1:0] bram_addr,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] bram_din
);

   localparam int unsigned AW      = C_S_AXI_ADDR_WIDTH;
   localparam int unsigned DW      = C_S_AXI_DATA_WIDTH;
   localparam int unsigned ENTRY_W = DW + 1;

   state_t                      state;
   logic [C_S_AXI_ID_WIDTH-1:0] rid_q;
   logic [AW-1:0]               addr_q;
   logic [LEN_W-1:0]            len_q;
   logic [LEN_W-1:0]            beat_q;
   logic [BURST_W-1:0]          burst_q;
   logic                        inflight_q;
   logic                        inflight_last_q;

   logic [1:0]                  fifo_count;
   logic [ENTRY_W-1:0]          fifo_head;

   logic                        arready_c;
   logic                        rvalid_c;
   logic                        pop_c;
   logic [2:0]                  occ_c;
   logic                        issue_c;
   logic                        last_issue_c;

   // ARREADY is masked by reset so it reads low while reset is held.
   assign arready_c    = (state == ST_IDLE) && !S_AXI_ARESET;
   assign rvalid_c     = (fifo_count != 2'd0);
   assign pop_c        = rvalid_c && s_axi.S_AXI_RREADY;
   // Occupancy after this edge, counting the read already in flight.
   assign occ_c        = 3'(fifo_count) + 3'(inflight_q) - 3'(pop_c);
   assign issue_c      = (state == ST_ISSUE) && (occ_c <= 3'd1);
   assign last_issue_c = issue_c && (beat_q == len_q);

   assign s_axi.S_AXI_ARREADY = arready_c;
   assign s_axi.S_AXI_RVALID  = rvalid_c;
   assign s_axi.S_AXI_RDATA   = fifo_head[DW-1:0];
   assign s_axi.S_AXI_RLAST   = fifo_head[DW];
   assign s_axi.S_AXI_RID     = rid_q;
   assign s_axi.S_AXI_RRESP   = RESP_OKAY;

   assign bram_clk  = S_AXI_ACLK;
   assign bram_rst  = S_AXI_ARESET;
   assign bram_en   = issue_c;
   assign bram_addr = addr_q;

   // Burst control: capture request, pace BRAM reads, wait for the last beat.
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         state           <= ST_IDLE;
         rid_q           <= '0;
         addr_q          <= '0;
         len_q           <= '0;
         beat_q          <= '0;
         burst_q         <= BURST_FIXED;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         inflight_q      <= issue_c;
         inflight_last_q <= last_issue_c;
         case (state)
            ST_IDLE: begin
               if (s_axi.S_AXI_ARVALID && arready_c) begin
                  rid_q   <= s_axi.S_AXI_ARID;
                  addr_q  <= s_axi.S_AXI_ARADDR;
                  len_q   <= s_axi.S_AXI_ARLEN;
                  burst_q <= s_axi.S_AXI_ARBURST;
                  beat_q  <= '0;
                  state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (issue_c) begin
                  if (burst_advances(burst_q)) begin
                     addr_q <= addr_q + AW'(1);
                  end
                  if (last_issue_c) begin
                     state <= ST_DRAIN;
                  end else begin
                     beat_q <= beat_q + LEN_W'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (pop_c && fifo_head[DW]) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   rd_skid_fifo #(
      .WIDTH (ENTRY_W)
   ) u_rd_skid_fifo (
      .clk       (S_AXI_ACLK),
      .rst       (S_AXI_ARESET),
      .push      (inflight_q),
      .push_data ({inflight_last_q, bram_din}),
      .pop       (pop_c),
      .head_data (fifo_head),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_bram_to_axi_read.sv
// Randomized and directed bench for bram_to_axi_read with a burst-level reference model.
module tb_bram_to_axi_read;
   import bram_to_axi_read_pkg::*;

   localparam int unsigned IDW = 16;
   localparam int unsigned DW  = 128;
   localparam int unsigned AW  = 14;

   localparam logic [DW-1:0] MEM0010 = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
   localparam logic [DW-1:0] MEM0020 = 128'h2020_0000_1111_2222_3333_4444_5555_6666;
   localparam logic [DW-1:0] MEM0023 = 128'h2323_7777_8888_9999_aaaa_bbbb_cccc_dddd;
   localparam logic [DW-1:0] MEM0005 = 128'hdead_beef_0000_0005_cafe_f00d_1234_5678;
   localparam logic [DW-1:0] MEM3FFE = 128'h3ffe_3ffe_0102_0304_0506_0708_090a_0b0c;
   localparam logic [DW-1:0] MEM0001 = 128'h0001_0001_a1a2_a3a4_a5a6_a7a8_a9aa_abac;

   typedef struct {
      logic [DW-1:0]  data;
      logic           last;
      logic [IDW-1:0] id;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          bram_clk, bram_rst, bram_en;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_din = '0;
   logic [DW-1:0] mem [0:(1<<AW)-1];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int rr_mode = 0;
   logic [3:0] rr_pat = 4'b1001;

   beat_t         exp_q[$];
   logic [AW-1:0] exp_addr_q[$];

   int hs_cyc, en_cyc, rv_cyc, arready_cyc, first_pop_cyc, last_pop_cyc;
   int n_pops = 0, n_rlast = 0, issued = 0, popped = 0;
   logic en_seen = 0, rv_seen = 0, ar_seen = 0, prev_v = 0, prev_r = 0, prev_l = 0;
   logic [DW-1:0]  prev_d, first_rdata, last_rdata;
   logic [IDW-1:0] first_rid;
   logic [AW-1:0]  first_en_addr, last_en_addr;

   bram_to_axi_read_if #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();

   bram_to_axi_read #(
      .C_S_AXI_ID_WIDTH   (IDW),
      .C_S_AXI_DATA_WIDTH (DW),
      .C_S_AXI_ADDR_WIDTH (AW)
   ) dut (
      .S_AXI_ACLK   (clk),
      .S_AXI_ARESET (rst),
      .s_axi        (ifc),
      .bram_clk     (bram_clk),
      .bram_rst     (bram_rst),
      .bram_en      (bram_en),
      .bram_addr    (bram_addr),
      .bram_din     (bram_din)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // BRAM: registered read, data valid the cycle after the strobe.
   always @(posedge clk) if (bram_en) bram_din <= mem[bram_addr];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // RREADY pattern generator.
   initial begin
      ifc.S_AXI_RREADY = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rr_mode)
            0:       ifc.S_AXI_RREADY = 1'b1;
            1:       ifc.S_AXI_RREADY = rr_pat[cyc[1:0]];
            default: ifc.S_AXI_RREADY = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Model update and per-cycle comparison of R channel and BRAM strobes.
   always @(negedge clk) begin : sampler
      beat_t         b;
      logic [AW-1:0] a;
      if (rst) begin
         exp_q.delete();
         exp_addr_q.delete();
         issued = 0;
         popped = 0;
         prev_v = 1'b0;
      end else begin
         if (bram_en) begin
            chk("bram_en_expected", DW'(exp_addr_q.size() != 0), 1);
            if (exp_addr_q.size() != 0) chk("bram_addr", bram_addr, exp_addr_q.pop_front());
            if (!en_seen) begin
               en_seen = 1'b1;
               en_cyc = cyc;
               first_en_addr = bram_addr;
            end
            last_en_addr = bram_addr;
            issued++;
         end
         if (ifc.S_AXI_RVALID) begin
            if (!rv_seen) begin
               rv_seen = 1'b1;
               rv_cyc = cyc;
            end
            if (ifc.S_AXI_RREADY) begin
               chk("beat_expected", DW'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  b = exp_q.pop_front();
                  chk("rdata", ifc.S_AXI_RDATA, b.data);
                  chk("rlast", ifc.S_AXI_RLAST, b.last);
                  chk("rid", ifc.S_AXI_RID, b.id);
                  chk("rresp", ifc.S_AXI_RRESP, RESP_OKAY);
               end
               if (n_pops == 0) begin
                  first_pop_cyc = cyc;
                  first_rdata = ifc.S_AXI_RDATA;
                  first_rid = ifc.S_AXI_RID;
               end
               last_pop_cyc = cyc;
               last_rdata = ifc.S_AXI_RDATA;
               n_pops++;
               if (ifc.S_AXI_RLAST) n_rlast++;
               popped++;
            end
         end
         if (bram_en || (ifc.S_AXI_RVALID && ifc.S_AXI_RREADY))
            chk("occupancy_le_2", DW'((issued - popped) <= 2), 1);
         if (prev_v && !prev_r) begin
            chk("stall_valid", ifc.S_AXI_RVALID, 1);
            chk("stall_data", ifc.S_AXI_RDATA, prev_d);
            chk("stall_last", ifc.S_AXI_RLAST, prev_l);
         end
         prev_v = ifc.S_AXI_RVALID;
         prev_r = ifc.S_AXI_RREADY;
         prev_d = ifc.S_AXI_RDATA;
         prev_l = ifc.S_AXI_RLAST;
         if (!ar_seen && cyc > hs_cyc && ifc.S_AXI_ARREADY) begin
            ar_seen = 1'b1;
            arready_cyc = cyc;
         end
         if (ifc.S_AXI_ARVALID && ifc.S_AXI_ARREADY) begin
            a = ifc.S_AXI_ARADDR;
            for (int i = 0; i <= int'(ifc.S_AXI_ARLEN); i++) begin
               b.data = mem[a];
               b.last = (i == int'(ifc.S_AXI_ARLEN));
               b.id   = ifc.S_AXI_ARID;
               exp_q.push_back(b);
               exp_addr_q.push_back(a);
               if (ifc.S_AXI_ARBURST != BURST_FIXED) a = a + AW'(1);
            end
            hs_cyc  = cyc;
            en_seen = 1'b0;
            rv_seen = 1'b0;
            ar_seen = 1'b0;
            n_pops  = 0;
            n_rlast = 0;
         end
      end
   end

   task automatic ar(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                     input logic [7:0] len, input logic [1:0] burst);
      logic ok;
      @(posedge clk);
      #1;
      ifc.S_AXI_ARID    = id;
      ifc.S_AXI_ARADDR  = addr;
      ifc.S_AXI_ARLEN   = len;
      ifc.S_AXI_ARBURST = burst;
      ifc.S_AXI_ARVALID = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 3000 && !ok; n++) begin
         @(negedge clk);
         ok = ifc.S_AXI_ARREADY;
      end
      chk("ar_accepted", ok, 1);
      @(posedge clk);
      #1;
      ifc.S_AXI_ARVALID = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      logic done;
      done = 1'b0;
      for (int n = 0; n < budget && !done; n++) begin
         @(negedge clk);
         done = (exp_q.size() == 0) && ifc.S_AXI_ARREADY;
      end
      chk("drain_done", done, 1);
      @(posedge clk);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] len;
      ifc.S_AXI_ARVALID = 1'b0;
      ifc.S_AXI_ARID    = '0;
      ifc.S_AXI_ARADDR  = '0;
      ifc.S_AXI_ARLEN   = '0;
      ifc.S_AXI_ARBURST = BURST_INCR;
      for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
      mem[14'h0010] = MEM0010;
      mem[14'h0020] = MEM0020;
      mem[14'h0023] = MEM0023;
      mem[14'h0005] = MEM0005;
      mem[14'h3FFE] = MEM3FFE;
      mem[14'h0001] = MEM0001;

      // Reset values.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_arready", ifc.S_AXI_ARREADY, 0);
      chk("rst_rvalid", ifc.S_AXI_RVALID, 0);
      chk("rst_rlast", ifc.S_AXI_RLAST, 0);
      chk("rst_bram_en", bram_en, 0);
      chk("rst_bram_addr", bram_addr, 0);
      chk("rst_rid", ifc.S_AXI_RID, 0);
      chk("rst_rdata", ifc.S_AXI_RDATA, 0);
      chk("rst_bram_rst", bram_rst, 1);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_arready", ifc.S_AXI_ARREADY, 1);

      // Single beat latency.
      rr_mode = 0;
      ar(16'h00A5, 14'h0010, 8'd0, BURST_INCR);
      wait_idle(100);
      chk("single_en_lat", DW'(en_cyc - hs_cyc), 1);
      chk("single_en_addr", first_en_addr, 14'h0010);
      chk("single_rv_lat", DW'(rv_cyc - hs_cyc), 3);
      chk("single_rdata", first_rdata, MEM0010);
      chk("single_rid", first_rid, 16'h00A5);
      chk("single_rlast_cnt", DW'(n_rlast), 1);
      chk("single_arready_lat", DW'(arready_cyc - hs_cyc), 4);

      // INCR, four beats back to back.
      ar(16'h0042, 14'h0020, 8'd3, BURST_INCR);
      wait_idle(100);
      chk("incr4_beats", DW'(n_pops), 4);
      chk("incr4_first_lat", DW'(first_pop_cyc - hs_cyc), 3);
      chk("incr4_last_lat", DW'(last_pop_cyc - hs_cyc), 6);
      chk("incr4_first_data", first_rdata, MEM0020);
      chk("incr4_last_data", last_rdata, MEM0023);
      chk("incr4_rlast_cnt", DW'(n_rlast), 1);

      // Backpressure.
      rr_mode = 1;
      ar(16'h0777, 14'h0100, 8'd7, BURST_INCR);
      wait_idle(300);
      chk("bp_beats", DW'(n_pops), 8);
      chk("bp_rlast_cnt", DW'(n_rlast), 1);

      // FIXED burst.
      rr_mode = 0;
      ar(16'h0F0F, 14'h0005, 8'd3, BURST_FIXED);
      wait_idle(100);
      chk("fixed_beats", DW'(n_pops), 4);
      chk("fixed_first", first_rdata, MEM0005);
      chk("fixed_last", last_rdata, MEM0005);
      chk("fixed_last_addr", last_en_addr, 14'h0005);

      // Address wrap at the top of the BRAM.
      ar(16'h3333, 14'h3FFE, 8'd3, BURST_INCR);
      wait_idle(100);
      chk("wrap_first_addr", first_en_addr, 14'h3FFE);
      chk("wrap_last_addr", last_en_addr, 14'h0001);
      chk("wrap_first", first_rdata, MEM3FFE);
      chk("wrap_last", last_rdata, MEM0001);

      // Reset in the middle of a burst.
      ar(16'h0BEE, 14'h0200, 8'd15, BURST_INCR);
      for (int n = 0; n < 200 && n_pops < 5; n++) @(negedge clk);
      chk("mid_five_beats", DW'(n_pops >= 5), 1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_rvalid", ifc.S_AXI_RVALID, 0);
      chk("mid_rst_bram_en", bram_en, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rel_arready", ifc.S_AXI_ARREADY, 1);
      ar(16'h1234, 14'h0010, 8'd0, BURST_INCR);
      wait_idle(100);
      chk("mid_after_beats", DW'(n_pops), 1);
      chk("mid_after_data", first_rdata, MEM0010);
      chk("mid_after_rid", first_rid, 16'h1234);

      // Longest burst at full rate.
      ar(16'hFFFF, 14'h3F00, 8'd255, BURST_INCR);
      wait_idle(600);
      chk("max_beats", DW'(n_pops), 256);
      chk("max_span", DW'(last_pop_cyc - first_pop_cyc), 255);
      chk("max_rlast_cnt", DW'(n_rlast), 1);

      // Random bursts with random backpressure, requests queued while busy.
      rr_mode = 2;
      for (int k = 0; k < 25; k++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         len = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
         ar(16'($urandom), 14'($urandom), len, 2'($urandom_range(0, 3)));
      end
      wait_idle(3000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bram_to_axi_read.md
BRAM_TO_AXI_READ -- requirements
Module: bram_to_axi_read

Interface
REQ-001 SHALL have parameter C_S_AXI_ID_WIDTH, default 16, AXI ID width.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 128, AXI and BRAM data width.
REQ-003 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 14, word address width.
REQ-004 One clock; reset is synchronous and active-high: S_AXI_ACLK input 1 (all logic on rising edge); S_AXI_ARESET input 1 (synchronous active-high reset).
REQ-005 S_AXI_ARID input ID_WIDTH, read request ID.
REQ-006 S_AXI_ARADDR input ADDR_WIDTH, start word address.
REQ-007 S_AXI_ARLEN input 8, beats minus one.
REQ-008 S_AXI_ARBURST input 2, burst type.
REQ-009 S_AXI_ARVALID input 1 / S_AXI_ARREADY output 1, AR handshake.
REQ-010 S_AXI_RID output ID_WIDTH; S_AXI_RDATA output DATA_WIDTH; S_AXI_RRESP output 2; S_AXI_RLAST output 1.
REQ-011 S_AXI_RVALID output 1 / S_AXI_RREADY input 1, R handshake.
REQ-012 bram_clk output 1 (=S_AXI_ACLK); bram_rst output 1 (=S_AXI_ARESET).
REQ-013 bram_en output 1, read strobe; bram_addr output ADDR_WIDTH; bram_din input DATA_WIDTH, read data valid one cycle after bram_en.

Function
REQ-014 FSM states: IDLE, ISSUE, DRAIN.
REQ-015 IDLE: ARREADY=1. On ARVALID&ARREADY, capture ARID, ARADDR, ARLEN, ARBURST; go to ISSUE. In every other state ARREADY=0.
REQ-016 ISSUE: bram_en=1 with bram_addr=current address iff (fifo_count + inflight - pop) <= 1, where pop = RVALID&RREADY and inflight = read issued in the previous cycle.
REQ-017 Issued beat index counts 0..ARLEN. After issuing beat ARLEN, go to DRAIN.
REQ-018 DRAIN: no BRAM reads. On pop of the RLAST beat, go to IDLE; next ARREADY=1 in the following cycle.
REQ-019 Address update per issue: ARBURST=00 (FIXED) holds the address. 01 and 10 increment by 1, modulo 2^ADDR_WIDTH (0x3FFF -> 0x0000). 11 is treated as INCR.
REQ-020 bram_din of an issued read SHALL be pushed into a 2-entry FIFO at the end of the cycle after issue, with a last flag set for beat ARLEN.
REQ-021 RVALID = FIFO non-empty. RDATA and RLAST come from the FIFO head. RID = captured ARID. RRESP = 2'b00 always.
REQ-022 Latency: AR handshake in cycle T -> bram_en in T+1 -> RVALID in T+3.
REQ-023 Throughput: with RREADY held high, one beat per cycle with no bubbles.
REQ-024 RDATA/RLAST SHALL stay stable while RVALID=1 and RREADY=0. The FIFO never overflows, and no read is issued while occupancy would exceed 2.
REQ-025 Simultaneous push and pop SHALL keep the count unchanged and preserve order.
REQ-026 ARLEN=255 SHALL produce 256 beats. The beat counter SHALL be 9 bits wide or compare on the 8-bit ARLEN without overflow.

Reset
REQ-027 While S_AXI_ARESET=1 at a clock edge: state=IDLE, FIFO empty, inflight=0, counters=0. Outputs: ARREADY=0, RVALID=0, RLAST=0, bram_en=0, bram_addr=0, RID=0, RDATA=0.
REQ-028 The first cycle after reset deasserts SHALL have ARREADY=1.
REQ-029 Reset mid-burst SHALL abort the burst: RVALID=0 in the next cycle, and a BRAM response still in flight is discarded.

Structure
REQ-030 A shared package SHALL hold: the state enum (IDLE/ISSUE/DRAIN), the burst-type constants (FIXED=00, INCR=01, WRAP=10), and RESP_OKAY=2'b00.
REQ-031 One sub-module, rd_skid_fifo: 2-entry, width DATA_WIDTH+1, push/pop/count, synchronous active-high reset.

Verification
REQ-032 Single beat: ARADDR=0x0010, ARLEN=0, ARID=0x00A5, RREADY=1 -> bram_en at T+1 with addr 0x0010. RVALID at T+3 with RDATA=mem[0x10], RLAST=1, RID=0x00A5. ARREADY=1 again at T+4.
REQ-033 INCR len 4: ARADDR=0x0020, ARLEN=3, RREADY=1 -> beats mem[0x20..0x23] in cycles T+3..T+6, RLAST only on the 4th beat.
REQ-034 Backpressure: ARLEN=7 with RREADY toggling 1,0,0,1,... -> all 8 beats in order, no loss or duplication, data stable while stalled, never more than 2 entries buffered.
REQ-035 FIXED and wrap: ARBURST=00, ARADDR=0x0005, ARLEN=3 -> four beats of mem[0x05]. INCR with ARADDR=0x3FFE, ARLEN=3 -> addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001.
REQ-036 Reset mid-burst: ARLEN=15, assert reset after 5 beats -> RVALID=0 the next cycle. After release, ARREADY=1 and a new ARLEN=0 read returns the correct data.
REQ-037 Max burst: ARLEN=255, RREADY=1 -> exactly 256 beats in 256 consecutive cycles, RLAST only on beat 256.
